// File: rtl/serial_deser_if.sv
// Serial deserialiser bus: bit stream and control in, words and status out.
interface serial_deser_if #(
    parameter int WIDTH = 8
);
    logic             en_n;
    logic             din;
    logic             resync;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             sync_found;
    logic             locked;
    logic [7:0]       word_cnt;

    // Bit source side
    modport master (
        output en_n, din, resync,
        input  data_out, data_valid, sync_found, locked, word_cnt
    );

    // Deserialiser side
    modport slave (
        input  en_n, din, resync,
        output data_out, data_valid, sync_found, locked, word_cnt
    );
endinterface

// File: rtl/serial_deser.sv
// Serial-to-parallel deserialiser: hunts for SYNC_PATTERN, then frames
// every following WIDTH enabled bits (MSB first) into a word.
module serial_deser #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(8'hA5)
) (
    input  logic            clk,
    input  logic            rst,
    serial_deser_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             sync_found;
    logic [7:0]       word_cnt;
    logic [WIDTH-1:0] next_word;

    // Shift register contents including the bit arriving on this edge
    assign next_word = {shreg[WIDTH-2:0], bus.din};

    // Alignment FSM, word framing and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            word_cnt   <= '0;
        end else begin
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            if (bus.resync) begin
                // Drop lock and discard the partial word, including this edge's bit
                state   <= HUNT;
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (!bus.en_n) begin
                shreg <= next_word;
                if (state == HUNT) begin
                    if (next_word == SYNC_PATTERN) begin
                        state      <= LOCKED;
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        sync_found <= 1'b1;
                    end
                end else if (bit_cnt == LAST_BIT) begin
                    // Pattern-valued words are plain data once locked
                    bit_cnt    <= '0;
                    data_out   <= next_word;
                    data_valid <= 1'b1;
                    word_cnt   <= word_cnt + 8'd1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.sync_found = sync_found;
    assign bus.locked     = (state == LOCKED);
    assign bus.word_cnt   = word_cnt;
endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the deserialised word width; legal range 2..16.
REQ-002 The block SHALL have parameter SYNC_PATTERN, default 8'hA5 (WIDTH bits), giving the alignment pattern searched for in HUNT.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port en_n, input, 1 bit: bit-enable, active-low; din is consumed only on edges where en_n=0.
REQ-006 The block SHALL have port din, input, 1 bit: serial data bit, MSB of each word first.
REQ-007 The block SHALL have port resync, input, 1 bit: synchronous request to drop lock and return to HUNT.
REQ-008 The block SHALL have port data_out, output, WIDTH bits: last completed word, registered.
REQ-009 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a new data_out.
REQ-010 The block SHALL have port sync_found, output, 1 bit: one-cycle pulse on acquiring alignment.
REQ-011 The block SHALL have port locked, output, 1 bit: high while in LOCKED state.
REQ-012 The block SHALL have port word_cnt, output, 8 bits: count of words delivered since lock, wraps modulo 256.

Function
REQ-013 The block SHALL implement a two-state FSM, HUNT and LOCKED, with HUNT as the reset state.
REQ-014 Each enabled edge SHALL shift: shreg <= {shreg[WIDTH-2:0], din}; disabled edges (en_n=1) SHALL hold shreg, bit_cnt, state and word_cnt.
REQ-015 In HUNT, on an enabled edge where {shreg[WIDTH-2:0], din} == SYNC_PATTERN, the block SHALL go to LOCKED, clear bit_cnt to 0, clear word_cnt to 0 and pulse sync_found on that edge.
REQ-016 In HUNT, data_valid SHALL remain 0 and data_out SHALL hold its value.
REQ-017 In LOCKED, bit_cnt SHALL increment 0..WIDTH-1 on each enabled edge; on the edge capturing bit WIDTH-1, it SHALL wrap to 0, load data_out with {shreg[WIDTH-2:0], din}, pulse data_valid and increment word_cnt.
REQ-018 Latency SHALL be zero added cycles: data_out/data_valid update on the same rising edge that samples the final bit.
REQ-019 data_valid and sync_found SHALL each be high for exactly one clock, then return to 0 regardless of en_n.
REQ-020 In LOCKED, a word equal to SYNC_PATTERN SHALL be treated as ordinary data, with no re-alignment.
REQ-021 word_cnt SHALL wrap from 255 to 0 without affecting state.
REQ-022 resync=1 on any edge SHALL force HUNT, clear shreg and bit_cnt, and discard any partial word; it SHALL take priority over en_n=0 on the same edge, and the din bit on that edge SHALL be discarded.
REQ-023 resync SHALL NOT alter data_out or word_cnt; locked SHALL fall on the same edge.
REQ-024 locked SHALL equal (state == LOCKED), registered.

Reset
REQ-025 rst=1 at a rising edge SHALL force state=HUNT, shreg=0, bit_cnt=0, data_out=0, data_valid=0, sync_found=0, locked=0 and word_cnt=0, overriding resync and en_n.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after rst falls, a full SYNC_PATTERN SHALL be required before any data_valid.

Verification
REQ-027 After reset, with en_n=0, drive bits 1,0,1,0,0,1,0,1 -> sync_found=1 and locked=1 after the 8th edge, data_valid=0.
REQ-028 Once locked, drive 0,0,1,1,1,1,0,0 -> data_out=8'h3C and data_valid=1 for one cycle after the 8th edge, word_cnt=1.
REQ-029 Repeat the 8'h3C word with en_n=1 for 3 cycles inserted after bit 4 -> identical data_out and word_cnt=2; no data_valid during the gap.
REQ-030 Assert resync after 5 bits of a word (with en_n=0 on that edge) -> locked=0 on that edge, data_out unchanged; a following 8'h3C without sync gives no data_valid; 8'hA5 then re-locks.
REQ-031 Assert rst mid-word while locked -> all outputs 0 on the next edge; word_cnt=0.
REQ-032 Deliver 256 words after lock, including one word equal to 8'hA5 -> every word gives a data_valid pulse, word_cnt returns to 0, and locked stays 1 throughout.
